gen_mdio_write_logic: RTL and testbench

//  MDIO-side write path into the 96 capture memories: takes a single-word write request from the register file,

---
 rtl/gen_mdio_write_logic.sv | 169 ++++++++++++++++
 tb/tb_gen_mdio_write_logic.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_mdio_write_logic.sv
// MDIO-side single-word write sequencer into the capture memories.
// Each accepted request runs SETUP -> WRITE (one-cycle strobe) -> HOLD(WR_GAP) and reports busy/done/errors.
module gen_mdio_write_logic #(
  parameter int NUM_MEM = 96,
  parameter int SELW    = 7,
  parameter int AW      = 15,
  parameter int DW      = 9,
  parameter int WR_GAP  = 2
) (
  input  logic                  clk_200m,
  input  logic                  rst_200m,
  input  logic                  mdio_wr_en,
  input  logic                  rf_mdio_write_en,
  input  logic [SELW-1:0]       rf_mdio_which_memory_sel,
  input  logic [AW-1:0]         rf_mdio_memory_addr,
  input  logic [DW-1:0]         rf_mdio_wdata,
  input  logic                  rf_mdio_wr_auto_inc,
  input  logic                  rf_mdio_addr_load,
  input  logic                  rf_mdio_err_clr,
  output logic [NUM_MEM-1:0]    mdio_wr_chip_en,
  output logic [NUM_MEM*AW-1:0] mdio_wr_waddr,
  output logic [DW-1:0]         mdio_wr_wdata,
  output logic                  mdio_wr_busy,
  output logic                  mdio_wr_done,
  output logic                  mdio_wr_sel_err,
  output logic                  mdio_wr_ovr_err,
  output logic [AW-1:0]         mdio_wr_ptr
);
  localparam int            CW        = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(WR_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_hold_cnt, w_hold_cnt_next;
  logic [SELW-1:0]       r_sel, w_sel_next;
  logic [AW-1:0]         r_addr, w_addr_next;
  logic [DW-1:0]         r_data, w_data_next;
  logic                  r_auto_inc, w_auto_inc_next;
  logic [AW-1:0]         r_ptr, w_ptr_next;
  logic                  r_sel_err, w_sel_err_next;
  logic                  r_ovr_err, w_ovr_err_next;
  logic                  r_done, w_done_next;
  logic                  r_busy;
  logic                  w_sel_ok;
  logic                  w_active_next;
  logic [NUM_MEM-1:0]    r_chip_en, w_chip_en_next;
  logic [NUM_MEM*AW-1:0] r_waddr, w_waddr_next;
  logic [DW-1:0]         r_wdata, w_wdata_next;

  assign w_sel_ok = ({1'b0, rf_mdio_which_memory_sel} < (SELW+1)'(NUM_MEM));

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_sel_next      = r_sel;
    w_addr_next     = r_addr;
    w_data_next     = r_data;
    w_auto_inc_next = r_auto_inc;
    w_ptr_next      = r_ptr;
    w_done_next     = 1'b0;
    w_sel_err_next  = r_sel_err & ~rf_mdio_err_clr;
    w_ovr_err_next  = r_ovr_err & ~rf_mdio_err_clr;

    if (!mdio_wr_en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rf_mdio_write_en) begin
            if (w_sel_ok) begin
              w_state_next    = ST_SETUP;
              w_sel_next      = rf_mdio_which_memory_sel;
              w_addr_next     = rf_mdio_wr_auto_inc ? r_ptr : rf_mdio_memory_addr;
              w_data_next     = rf_mdio_wdata;
              w_auto_inc_next = rf_mdio_wr_auto_inc;
            end else begin
              w_sel_err_next = 1'b1;
              w_done_next    = 1'b1;
            end
          end
        end
        ST_SETUP: w_state_next = ST_WRITE;
        ST_WRITE: begin
          w_state_next    = ST_HOLD;
          w_hold_cnt_next = '0;
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    if (mdio_wr_en && rf_mdio_write_en && (r_state != ST_IDLE))
      w_ovr_err_next = 1'b1;

    // The strobe has already gone out in WRITE, so the pointer advances even if the sequence aborts there.
    if ((r_state == ST_WRITE) && r_auto_inc)
      w_ptr_next = r_ptr + 1'b1;
    if (rf_mdio_addr_load)
      w_ptr_next = rf_mdio_memory_addr;
  end

  assign w_active_next = (w_state_next != ST_IDLE);
  assign w_wdata_next  = w_active_next ? w_data_next : '0;

  generate
    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem
      assign w_chip_en_next[gi] = (w_state_next == ST_WRITE) && (w_sel_next == SELW'(gi));
      assign w_waddr_next[gi*AW +: AW] =
        (w_active_next && (w_sel_next == SELW'(gi))) ? w_addr_next : '0;
    end
  endgenerate

  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_auto_inc <= 1'b0;
      r_ptr      <= '0;
      r_sel_err  <= 1'b0;
      r_ovr_err  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_chip_en  <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_sel      <= w_sel_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
      r_auto_inc <= w_auto_inc_next;
      r_ptr      <= w_ptr_next;
      r_sel_err  <= w_sel_err_next;
      r_ovr_err  <= w_ovr_err_next;
      r_done     <= w_done_next;
      r_busy     <= w_active_next;
      r_chip_en  <= w_chip_en_next;
      r_waddr    <= w_waddr_next;
      r_wdata    <= w_wdata_next;
    end
  end

  assign mdio_wr_chip_en = r_chip_en;
  assign mdio_wr_waddr   = r_waddr;
  assign mdio_wr_wdata   = r_wdata;
  assign mdio_wr_busy    = r_busy;
  assign mdio_wr_done    = r_done;
  assign mdio_wr_sel_err = r_sel_err;
  assign mdio_wr_ovr_err = r_ovr_err;
  assign mdio_wr_ptr     = r_ptr;

endmodule

// File: tb/tb_gen_mdio_write_logic.sv
// Bench for gen_mdio_write_logic: table of single writes, hand-written corner sequences,
// and a randomized run against a phase-counting reference model checked every cycle.
module tb_gen_mdio_write_logic;
  localparam int NUM_MEM = 96;
  localparam int SELW    = 7;
  localparam int AW      = 15;
  localparam int DW      = 9;
  localparam int WR_GAP  = 2;

  logic                  clk_200m = 1'b0;
  logic                  rst_200m = 1'b1;
  logic                  mdio_wr_en = 1'b0;
  logic                  rf_mdio_write_en = 1'b0;
  logic [SELW-1:0]       rf_mdio_which_memory_sel = '0;
  logic [AW-1:0]         rf_mdio_memory_addr = '0;
  logic [DW-1:0]         rf_mdio_wdata = '0;
  logic                  rf_mdio_wr_auto_inc = 1'b0;
  logic                  rf_mdio_addr_load = 1'b0;
  logic                  rf_mdio_err_clr = 1'b0;
  logic [NUM_MEM-1:0]    mdio_wr_chip_en;
  logic [NUM_MEM*AW-1:0] mdio_wr_waddr;
  logic [DW-1:0]         mdio_wr_wdata;
  logic                  mdio_wr_busy;
  logic                  mdio_wr_done;
  logic                  mdio_wr_sel_err;
  logic                  mdio_wr_ovr_err;
  logic [AW-1:0]         mdio_wr_ptr;

  gen_mdio_write_logic #(
    .NUM_MEM(NUM_MEM), .SELW(SELW), .AW(AW), .DW(DW), .WR_GAP(WR_GAP)
  ) dut (
    .clk_200m                (clk_200m),
    .rst_200m                (rst_200m),
    .mdio_wr_en              (mdio_wr_en),
    .rf_mdio_write_en        (rf_mdio_write_en),
    .rf_mdio_which_memory_sel(rf_mdio_which_memory_sel),
    .rf_mdio_memory_addr     (rf_mdio_memory_addr),
    .rf_mdio_wdata           (rf_mdio_wdata),
    .rf_mdio_wr_auto_inc     (rf_mdio_wr_auto_inc),
    .rf_mdio_addr_load       (rf_mdio_addr_load),
    .rf_mdio_err_clr         (rf_mdio_err_clr),
    .mdio_wr_chip_en         (mdio_wr_chip_en),
    .mdio_wr_waddr           (mdio_wr_waddr),
    .mdio_wr_wdata           (mdio_wr_wdata),
    .mdio_wr_busy            (mdio_wr_busy),
    .mdio_wr_done            (mdio_wr_done),
    .mdio_wr_sel_err         (mdio_wr_sel_err),
    .mdio_wr_ovr_err         (mdio_wr_ovr_err),
    .mdio_wr_ptr             (mdio_wr_ptr)
  );

  always #5 clk_200m = ~clk_200m;

  int tests = 0;
  int fails = 0;

  // Reference model: m_ph counts cycles since acceptance (0 = idle, 1 = setup, 2 = strobe, 3..2+WR_GAP = hold).
  int              m_ph;
  logic [SELW-1:0] m_sel;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [AW-1:0]   m_ptr;
  bit              m_auto, m_done, m_sel_err, m_ovr_err;

  typedef struct {
    logic [SELW-1:0] sel;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    int              exp_strobes;
    int              exp_idx;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
    bit              exp_sel_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_waddr(input logic [NUM_MEM*AW-1:0] exp);
    bit reported;
    tests++;
    if (mdio_wr_waddr !== exp) begin
      fails++;
      reported = 0;
      for (int s = 0; s < NUM_MEM; s++) begin
        if (!reported && (mdio_wr_waddr[s*AW +: AW] !== exp[s*AW +: AW])) begin
          $display("FAIL waddr slice %0d: got 0x%0h expected 0x%0h (t=%0t)",
                   s, mdio_wr_waddr[s*AW +: AW], exp[s*AW +: AW], $time);
          reported = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_sel = '0; m_addr = '0; m_data = '0; m_ptr = '0;
    m_auto = 0; m_done = 0; m_sel_err = 0; m_ovr_err = 0;
  endtask

  task automatic model_step();
    int            ph_n;
    bit            done_n, set_sel, set_ovr;
    logic [AW-1:0] ptr_n;
    ph_n = m_ph; done_n = 0; set_sel = 0; set_ovr = 0; ptr_n = m_ptr;
    if (m_ph == 2 && m_auto) ptr_n = m_ptr + 15'd1;
    if (!mdio_wr_en) begin
      ph_n = 0;
    end else if (m_ph == 0) begin
      if (rf_mdio_write_en) begin
        if (int'(rf_mdio_which_memory_sel) < NUM_MEM) begin
          m_sel  = rf_mdio_which_memory_sel;
          m_addr = rf_mdio_wr_auto_inc ? m_ptr : rf_mdio_memory_addr;
          m_data = rf_mdio_wdata;
          m_auto = rf_mdio_wr_auto_inc;
          ph_n   = 1;
        end else begin
          set_sel = 1;
          done_n  = 1;
        end
      end
    end else if (m_ph == 2 + WR_GAP) begin
      ph_n   = 0;
      done_n = 1;
    end else begin
      ph_n = m_ph + 1;
    end
    if (mdio_wr_en && rf_mdio_write_en && m_ph != 0) set_ovr = 1;
    if (rf_mdio_addr_load) ptr_n = rf_mdio_memory_addr;
    m_sel_err = set_sel | (m_sel_err & !rf_mdio_err_clr);
    m_ovr_err = set_ovr | (m_ovr_err & !rf_mdio_err_clr);
    m_ph   = ph_n;
    m_done = done_n;
    m_ptr  = ptr_n;
  endtask

  task automatic compare_all();
    logic [NUM_MEM*AW-1:0] e_wa;
    logic [127:0]          e_ce;
    e_wa = '0;
    e_ce = '0;
    if (m_ph != 0) e_wa[int'(m_sel)*AW +: AW] = m_addr;
    if (m_ph == 2) e_ce[m_sel] = 1'b1;
    chk("chip_en", 128'(mdio_wr_chip_en), e_ce);
    chk_waddr(e_wa);
    chk("wdata",   128'(mdio_wr_wdata),   128'((m_ph != 0) ? m_data : 9'd0));
    chk("busy",    128'(mdio_wr_busy),    128'(m_ph != 0));
    chk("done",    128'(mdio_wr_done),    128'(m_done));
    chk("sel_err", 128'(mdio_wr_sel_err), 128'(m_sel_err));
    chk("ovr_err", 128'(mdio_wr_ovr_err), 128'(m_ovr_err));
    chk("ptr",     128'(mdio_wr_ptr),     128'(m_ptr));
  endtask

  // One clock: model follows the inputs the DUT samples, outputs checked at the falling edge, pulses cleared.
  task automatic cycle();
    model_step();
    @(posedge clk_200m);
    @(negedge clk_200m);
    compare_all();
    rf_mdio_write_en  = 1'b0;
    rf_mdio_addr_load = 1'b0;
    rf_mdio_err_clr   = 1'b0;
  endtask

  task automatic do_write(input logic [SELW-1:0] sel, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit auto_inc,
                          output int nstrobe, output int idx, output logic [AW-1:0] saddr,
                          output logic [DW-1:0] sdata, output bit done_seen);
    nstrobe = 0; idx = -1; saddr = '0; sdata = '0; done_seen = 0;
    rf_mdio_write_en         = 1'b1;
    rf_mdio_which_memory_sel = sel;
    rf_mdio_memory_addr      = addr;
    rf_mdio_wdata            = data;
    rf_mdio_wr_auto_inc      = auto_inc;
    cycle();
    for (int k = 0; k < 12 && !done_seen; k++) begin
      if (mdio_wr_chip_en != '0) begin
        nstrobe++;
        for (int b = 0; b < NUM_MEM; b++)
          if (mdio_wr_chip_en[b]) idx = b;
        if (idx >= 0) saddr = mdio_wr_waddr[idx*AW +: AW];
        sdata = mdio_wr_wdata;
      end
      if (mdio_wr_done) done_seen = 1;
      else cycle();
    end
  endtask

  initial begin
    int            ns, ix;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    bit            dn, any_done;
    logic [AW-1:0] exp_seq[3];

    vecs[0] = '{7'd5,   15'h0123, 9'h1A5, 1, 5,  15'h0123, 9'h1A5, 1'b0};
    vecs[1] = '{7'd0,   15'h7FFF, 9'h1FF, 1, 0,  15'h7FFF, 9'h1FF, 1'b0};
    vecs[2] = '{7'd95,  15'h0000, 9'h000, 1, 95, 15'h0000, 9'h000, 1'b0};
    vecs[3] = '{7'd47,  15'h2AAA, 9'h155, 1, 47, 15'h2AAA, 9'h155, 1'b0};
    vecs[4] = '{7'd96,  15'h1111, 9'h0AA, 0, 0,  15'h0000, 9'h000, 1'b1};
    vecs[5] = '{7'd127, 15'h5555, 9'h0F0, 0, 0,  15'h0000, 9'h000, 1'b1};

    model_reset();
    repeat (3) @(negedge clk_200m);
    rst_200m = 1'b0;
    compare_all();
    mdio_wr_en = 1'b1;

    // Exact timing of a single direct write.
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd5;
    rf_mdio_memory_addr = 15'h0123; rf_mdio_wdata = 9'h1A5; rf_mdio_wr_auto_inc = 1'b0;
    cycle();
    chk("t1_setup_busy", 128'(mdio_wr_busy), 128'(1));
    chk("t1_setup_ce",   128'(mdio_wr_chip_en), 128'(0));
    cycle();
    chk("t1_write_ce",    128'(mdio_wr_chip_en), 128'(1) << 5);
    chk("t1_write_waddr", 128'(mdio_wr_waddr[75 +: 15]), 128'(15'h0123));
    chk("t1_write_wdata", 128'(mdio_wr_wdata), 128'(9'h1A5));
    cycle();
    cycle();
    chk("t1_hold_busy", 128'(mdio_wr_busy), 128'(1));
    chk("t1_hold_ce",   128'(mdio_wr_chip_en), 128'(0));
    cycle();
    chk("t1_done",      128'(mdio_wr_done), 128'(1));
    chk("t1_idle_busy", 128'(mdio_wr_busy), 128'(0));
    chk("t1_idle_wa",   128'(|mdio_wr_waddr), 128'(0));

    // Table of single writes in direct mode, including out-of-range selects.
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].sel, vecs[i].addr, vecs[i].data, 1'b0, ns, ix, sa, sd, dn);
      chk($sformatf("vec%0d_done", i), 128'(dn), 128'(1));
      chk($sformatf("vec%0d_strobes", i), 128'(ns), 128'(vecs[i].exp_strobes));
      if (vecs[i].exp_strobes != 0) begin
        chk($sformatf("vec%0d_idx", i),   128'(ix), 128'(vecs[i].exp_idx));
        chk($sformatf("vec%0d_addr", i),  128'(sa), 128'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_data", i),  128'(sd), 128'(vecs[i].exp_data));
      end
      chk($sformatf("vec%0d_sel_err", i), 128'(mdio_wr_sel_err), 128'(vecs[i].exp_sel_err));
      chk($sformatf("vec%0d_busy", i),    128'(mdio_wr_busy), 128'(0));
      rf_mdio_err_clr = 1'b1;
      cycle();
      chk($sformatf("vec%0d_err_clr", i), 128'(mdio_wr_sel_err), 128'(0));
    end

    // Auto-increment across the pointer wrap.
    rf_mdio_addr_load = 1'b1; rf_mdio_memory_addr = 15'h7FFE;
    cycle();
    chk("t2_load", 128'(mdio_wr_ptr), 128'(15'h7FFE));
    exp_seq[0] = 15'h7FFE; exp_seq[1] = 15'h7FFF; exp_seq[2] = 15'h0000;
    for (int i = 0; i < 3; i++) begin
      do_write(7'd95, 15'h0444, 9'(i + 1), 1'b1, ns, ix, sa, sd, dn);
      chk($sformatf("t2_addr%0d", i), 128'(sa), 128'(exp_seq[i]));
      chk($sformatf("t2_idx%0d", i),  128'(ix), 128'(95));
    end
    chk("t2_ptr", 128'(mdio_wr_ptr), 128'(15'h0001));

    // Overrun during busy is dropped; a request in the done cycle is accepted.
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd10;
    rf_mdio_memory_addr = 15'h0AAA; rf_mdio_wdata = 9'h0F0; rf_mdio_wr_auto_inc = 1'b0;
    cycle();
    cycle();
    chk("t4_strobeA", 128'(mdio_wr_chip_en), 128'(1) << 10);
    cycle();
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd20; rf_mdio_memory_addr = 15'h0BBB;
    cycle();
    chk("t4_ovr_err", 128'(mdio_wr_ovr_err), 128'(1));
    chk("t4_busy",    128'(mdio_wr_busy), 128'(1));
    cycle();
    chk("t4_done",    128'(mdio_wr_done), 128'(1));
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd11;
    rf_mdio_memory_addr = 15'h0CCC; rf_mdio_wdata = 9'h033;
    cycle();
    chk("t4_accept_busy", 128'(mdio_wr_busy), 128'(1));
    cycle();
    chk("t4_strobeC", 128'(mdio_wr_chip_en), 128'(1) << 11);
    chk("t4_addrC",   128'(mdio_wr_waddr[11*AW +: AW]), 128'(15'h0CCC));
    repeat (3) cycle();
    chk("t4_doneC",   128'(mdio_wr_done), 128'(1));

    // Abort during SETUP: no strobe, no done, pointer untouched.
    rf_mdio_err_clr = 1'b1; rf_mdio_addr_load = 1'b1; rf_mdio_memory_addr = 15'h1234;
    cycle();
    chk("t5_ovr_clr", 128'(mdio_wr_ovr_err), 128'(0));
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd3;
    rf_mdio_wr_auto_inc = 1'b1; rf_mdio_wdata = 9'h101;
    cycle();
    mdio_wr_en = 1'b0;
    cycle();
    chk("t5_busy",  128'(mdio_wr_busy), 128'(0));
    chk("t5_ce",    128'(mdio_wr_chip_en), 128'(0));
    chk("t5_wa",    128'(|mdio_wr_waddr), 128'(0));
    chk("t5_wdata", 128'(mdio_wr_wdata), 128'(0));
    chk("t5_ptr",   128'(mdio_wr_ptr), 128'(15'h1234));
    mdio_wr_en = 1'b1;
    any_done = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (mdio_wr_done) any_done = 1;
    end
    chk("t5_no_done", 128'(any_done), 128'(0));

    // Asynchronous reset in the middle of WRITE.
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd100;
    cycle();
    rf_mdio_write_en = 1'b1; rf_mdio_which_memory_sel = 7'd7; rf_mdio_wr_auto_inc = 1'b1;
    cycle();
    cycle();
    chk("t6_strobe", 128'(mdio_wr_chip_en), 128'(1) << 7);
    chk("t6_pre_sel_err", 128'(mdio_wr_sel_err), 128'(1));
    #2 rst_200m = 1'b1;
    #1;
    chk("t6_ce",      128'(mdio_wr_chip_en), 128'(0));
    chk("t6_busy",    128'(mdio_wr_busy), 128'(0));
    chk("t6_ptr",     128'(mdio_wr_ptr), 128'(0));
    chk("t6_sel_err", 128'(mdio_wr_sel_err), 128'(0));
    chk("t6_wa",      128'(|mdio_wr_waddr), 128'(0));
    @(negedge clk_200m);
    rst_200m = 1'b0;
    model_reset();
    rf_mdio_write_en = 1'b0; rf_mdio_addr_load = 1'b0; rf_mdio_err_clr = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      mdio_wr_en               = ($urandom_range(0, 19) != 0);
      rf_mdio_write_en         = ($urandom_range(0, 3) == 0);
      rf_mdio_which_memory_sel = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(96, 127))
                                                             : 7'($urandom_range(0, 95));
      rf_mdio_memory_addr      = ($urandom_range(0, 3) == 0) ? 15'h7FFE : 15'($urandom);
      rf_mdio_wdata            = 9'($urandom);
      rf_mdio_wr_auto_inc      = ($urandom_range(0, 1) == 1);
      rf_mdio_addr_load        = ($urandom_range(0, 19) == 0);
      rf_mdio_err_clr          = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
